// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: enumerates every 6-bit word with exactly k ones, in
// ascending order, one word per valid/ready transfer.
//
// Handshake: word/idx/total are presented with valid=1 and stay frozen
// until a rising edge sees valid && ready; that edge is the transfer. The
// producer never withdraws valid before the transfer, and ready has no
// combinational path to any output.
module ones_pattern_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] k,
    input  logic       ready,
    output logic [5:0] word,
    output logic       valid,
    output logic [4:0] idx,
    output logic [4:0] total,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] word_q,  word_d;
    logic [4:0] idx_q,   idx_d;
    logic [4:0] total_q, total_d;
    logic       valid_q, valid_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;
    logic       err_q,   err_d;

    // Number of 6-bit words with kk ones, C(6,kk).
    function automatic logic [4:0] binom6(input logic [2:0] kk);
        logic [4:0] c;
        case (kk)
            3'd0:    c = 5'd1;
            3'd1:    c = 5'd6;
            3'd2:    c = 5'd15;
            3'd3:    c = 5'd20;
            3'd4:    c = 5'd15;
            3'd5:    c = 5'd6;
            3'd6:    c = 5'd1;
            default: c = 5'd0;
        endcase
        return c;
    endfunction

    // Smallest larger value with the same popcount. The lowest run of ones
    // is carried one place up and the leftover ones are packed at bit 0;
    // the divide by the lowest set bit is replaced by a trailing-zero shift.
    function automatic logic [5:0] next_perm(input logic [5:0] x);
        logic [6:0] xe;
        logic [6:0] lowest;
        logic [6:0] ripple;
        logic [6:0] ones;
        logic [6:0] res;
        logic [2:0] tz;
        xe     = {1'b0, x};
        lowest = xe & (~xe + 7'd1);
        ripple = xe + lowest;
        tz     = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (x[i]) tz = 3'(i);
        end
        ones = ((ripple ^ xe) >> 2) >> tz;
        res  = ripple | ones;
        return res[5:0];
    endfunction

    logic       xfer;
    logic       last_xfer;
    logic [6:0] first_word;

    assign xfer       = valid_q && ready;
    assign last_xfer  = (idx_q == (total_q - 5'd1));
    assign first_word = (7'd1 << k) - 7'd1;

    // Next-state and next-output computation for the enumeration FSM.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        total_d = total_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    if (k > 3'd6) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        word_d  = first_word[5:0];
                        idx_d   = 5'd0;
                        total_d = binom6(k);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    if (last_xfer) begin
                        state_d = FIN;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        word_d = next_perm(word_q);
                        idx_d  = idx_q + 5'd1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= 6'd0;
            idx_q   <= 5'd0;
            total_q <= 5'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            total_q <= total_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign word  = word_q;
    assign valid = valid_q;
    assign idx   = idx_q;
    assign total = total_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Bench for ones_pattern_gen: table of per-k expectations, randomized
// backpressure runs against an enumeration model, and hand-written
// sequences for error, reset-mid-run and ignored-start cases.
module tb_ones_pattern_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] k;
    logic       ready;
    logic [5:0] word;
    logic       valid;
    logic [4:0] idx;
    logic [4:0] total;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] exp_q[$];
    bit         seen[64];
    int         n_distinct;

    ones_pattern_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .k     (k),
        .ready (ready),
        .word  (word),
        .valid (valid),
        .idx   (idx),
        .total (total),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    // Clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every 6-bit value with kk ones, ascending.
    task automatic build_model(input int kk);
        exp_q.delete();
        for (int v = 0; v < 64; v++) begin
            if ($countones(v) == kk) exp_q.push_back(6'(v));
        end
    endtask

    // Drive one enumeration and score every presented word.
    task automatic run_k(input int kk, input int ready_pct, input bit inject,
                         output int n_xfer, output logic [5:0] first_w,
                         output logic [5:0] last_w);
        int         exp_total;
        bit         holding;
        bit         fin_seen;
        logic [5:0] held_w;
        logic [4:0] held_i;
        logic [5:0] e;
        build_model(kk);
        exp_total = exp_q.size();
        n_xfer    = 0;
        holding   = 1'b0;
        fin_seen  = 1'b0;
        first_w   = 6'd0;
        last_w    = 6'd0;
        held_w    = 6'd0;
        held_i    = 5'd0;
        @(negedge clk);
        start = 1'b1;
        k     = 3'(kk);
        ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("start_latency_valid", int'(valid), 1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (n_xfer == exp_total) begin
                chk("done_pulse", int'(done), 1);
                chk("fin_valid", int'(valid), 0);
                chk("fin_busy", int'(busy), 1);
                fin_seen = 1'b1;
                break;
            end
            chk("run_valid", int'(valid), 1);
            chk("run_busy", int'(busy), 1);
            chk("run_total", int'(total), exp_total);
            if (holding) begin
                chk("hold_word", int'(word), int'(held_w));
                chk("hold_idx", int'(idx), int'(held_i));
            end else begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", int'(word), int'(e));
                    chk("idx", int'(idx), n_xfer);
                    chk("popcount", $countones(word), kk);
                    if (!seen[word]) begin
                        seen[word] = 1'b1;
                        n_distinct++;
                    end
                end
                if (n_xfer == 0) first_w = word;
                last_w = word;
            end
            ready = ($urandom_range(0, 99) < ready_pct);
            if (inject && cyc == 3) begin
                start = 1'b1;
                k     = 3'd5;
            end else begin
                start = 1'b0;
            end
            holding = !ready;
            held_w  = word;
            held_i  = idx;
            if (ready) n_xfer++;
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b0;
        if (!fin_seen) chk("run_timeout", 0, 1);
        chk("model_drained", exp_q.size(), 0);
        @(negedge clk);
        chk("post_busy", int'(busy), 0);
        chk("post_done", int'(done), 0);
        chk("post_valid", int'(valid), 0);
    endtask

    typedef struct {
        int         k;
        int         exp_total;
        logic [5:0] exp_first;
        logic [5:0] exp_last;
        bit         exp_err;
    } vec_t;

    initial begin
        vec_t       vecs[8];
        int         n;
        int         n_sum;
        int         prev_total;
        logic [5:0] prev_last;
        logic [5:0] fw;
        logic [5:0] lw;
        logic [5:0] ref_w;

        vecs[0] = '{0, 1,  6'b000000, 6'b000000, 1'b0};
        vecs[1] = '{1, 6,  6'b000001, 6'b100000, 1'b0};
        vecs[2] = '{2, 15, 6'b000011, 6'b110000, 1'b0};
        vecs[3] = '{3, 20, 6'b000111, 6'b111000, 1'b0};
        vecs[4] = '{4, 15, 6'b001111, 6'b111100, 1'b0};
        vecs[5] = '{5, 6,  6'b011111, 6'b111110, 1'b0};
        vecs[6] = '{6, 1,  6'b111111, 6'b111111, 1'b0};
        vecs[7] = '{7, 0,  6'b000000, 6'b000000, 1'b1};

        // Reset block
        rst_n = 1'b0;
        start = 1'b0;
        k     = 3'd0;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_word", int'(word), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_idx", int'(idx), 0);
        chk("rst_total", int'(total), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table sweep k=0..7, ready held high
        foreach (seen[i]) seen[i] = 1'b0;
        n_distinct = 0;
        n_sum      = 0;
        prev_total = 0;
        prev_last  = 6'd0;
        for (int r = 0; r < 8; r++) begin
            if (vecs[r].exp_err) begin
                @(negedge clk);
                start = 1'b1;
                k     = 3'(vecs[r].k);
                @(negedge clk);
                start = 1'b0;
                chk("err_pulse", int'(err), 1);
                chk("err_valid", int'(valid), 0);
                chk("err_busy", int'(busy), 0);
                chk("err_word_kept", int'(word), int'(prev_last));
                chk("err_idx_kept", int'(idx), prev_total - 1);
                chk("err_total_kept", int'(total), prev_total);
                @(negedge clk);
                chk("err_one_cycle", int'(err), 0);
                chk("err_busy_after", int'(busy), 0);
                chk("err_valid_after", int'(valid), 0);
            end else begin
                run_k(vecs[r].k, 100, 1'b0, n, fw, lw);
                chk("tbl_count", n, vecs[r].exp_total);
                chk("tbl_first", int'(fw), int'(vecs[r].exp_first));
                chk("tbl_last", int'(lw), int'(vecs[r].exp_last));
                n_sum      = n_sum + n;
                prev_total = vecs[r].exp_total;
                prev_last  = vecs[r].exp_last;
            end
        end
        chk("sweep_sum", n_sum, 64);
        chk("sweep_distinct", n_distinct, 64);

        // k=3 with random backpressure
        run_k(3, 45, 1'b0, n, fw, lw);
        chk("bp_count", n, 20);
        chk("bp_last", int'(lw), 56);

        // start with k=5 pulsed during a k=4 run is ignored
        run_k(4, 100, 1'b1, n, fw, lw);
        chk("inject_count", n, 15);
        chk("inject_last", int'(lw), 60);

        // Random runs: random k and backpressure density
        for (int t = 0; t < 6; t++) begin
            int rk;
            rk = $urandom_range(0, 6);
            run_k(rk, $urandom_range(20, 100), 1'b0, n, fw, lw);
            build_model(rk);
            chk("rand_count", n, exp_q.size());
            exp_q.delete();
        end

        // Reset after the 4th transfer of a k=3 run
        build_model(3);
        ref_w = exp_q[4];
        exp_q.delete();
        @(negedge clk);
        start = 1'b1;
        k     = 3'd3;
        @(negedge clk);
        start = 1'b0;
        ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_idx", int'(idx), 4);
        chk("pre_rst_word", int'(word), int'(ref_w));
        rst_n = 1'b0;
        #1;
        chk("async_rst_word", int'(word), 0);
        chk("async_rst_valid", int'(valid), 0);
        chk("async_rst_idx", int'(idx), 0);
        chk("async_rst_total", int'(total), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_err", int'(err), 0);
        ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_resume_valid", int'(valid), 0);
        chk("no_resume_busy", int'(busy), 0);
        run_k(1, 100, 1'b0, n, fw, lw);
        chk("restart_count", n, 6);
        chk("restart_first", int'(fw), 1);
        chk("restart_last", int'(lw), 32);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ones_pattern_gen.md
# ones_pattern_gen

Sequential inverse of the combinational ones counter. Given a target count `k`, it enumerates every 6-bit word whose population count equals `k`, in ascending numeric order, one word per valid/ready transfer. Downstream logic uses it as a stimulus and pattern source, and the ones counter checks each emitted word.

## Interface
Parameters:
- none. The word width is fixed at 6 and the count width at 3.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — request an enumeration. Sampled only in IDLE.
- `k`  in  3  — target number of ones. Sampled together with `start`.
- `ready`  in  1  — downstream accepts `word` this cycle.
- `word`  out  6  — current pattern. Meaningful only while `valid` = 1.
- `valid`  out  1  — `word` is valid.
- `idx`  out  5  — 0-based position of `word` in the sequence.
- `total`  out  5  — number of words in the sequence, C(6,k), latched at start.
- `busy`  out  1  — high in every state other than IDLE.
- `done`  out  1  — one-cycle pulse after the last word is accepted.
- `err`  out  1  — one-cycle pulse when `start` arrives with `k` > 6.

## Operation
- States are IDLE, RUN and FIN.
- IDLE:
  - `start`=1 and `k`≤6 moves to RUN. It latches `k`, sets `word`=(1<<k)−1, `idx`=0 and `total`=C(6,k).
  - `start`=1 and `k`>6 stays in IDLE and pulses `err` for one cycle. `word`, `idx` and `total` are unchanged.
- RUN:
  - `valid`=1.
  - A transfer occurs when `valid`&&`ready` at a rising edge.
  - On a transfer that is not the last, `word` becomes the smallest larger 6-bit value with the same popcount, and `idx` increments.
  - The last word is (2^k−1)<<(6−k). Equivalently, the last transfer is the one with `idx`==`total`−1. On the last transfer the FSM moves to FIN.
- FIN: lasts one cycle with `done`=1, `valid`=0 and `busy`=1, then returns to IDLE.
- The C(6,k) values for k=0..6 are 1, 6, 15, 20, 15, 6, 1, from a constant lookup.
- `k`=0 produces the single word 000000. `k`=6 produces the single word 111111.
- `start` is ignored in RUN and FIN. Changes to `k` outside the IDLE sample edge have no effect.
- Backpressure: while `valid`=1 and `ready`=0, `word`, `idx` and `total` hold stable.
- Every emitted word must satisfy popcount(`word`)==latched `k`. No word repeats and none is skipped.

## Timing
- Reset (asynchronous, any time, including mid-RUN):
  - State returns to IDLE immediately.
  - `word`=0, `valid`=0, `idx`=0, `total`=0, `busy`=0, `done`=0, `err`=0.
  - No partial sequence resumes after reset is released.
- Start latency: `start` is sampled at edge E. `valid`=1 and the first word appear in the cycle after E.
- Throughput: one word per cycle while `ready`=1.
- With `ready` held at 1, transfers occur at edges E+1 … E+total. `done`=1 in the cycle after edge E+total, and `busy` falls one cycle later.
- `err` is high in the cycle after the sampling edge and only for that cycle. `busy` stays 0 throughout.
- A new `start` is accepted no earlier than the first IDLE cycle after FIN.
- All outputs are registered. There is no combinational path from `ready` or `start` to any output.

## Test plan
- **k=2, ready=1:**
  - Expect 15 words: 000011, 000101, 000110, 001001, 001010, 001100, 010001, … , 110000.
  - `idx` runs 0..14 and `total`=15.
  - `done` pulses in the cycle after the 15th transfer.
  - Every word checks popcount=2 against the ones counter.
- **k=0, then k=6:** expect the single word 000000 with `total`=1, then the single word 111111 with `total`=1. Each is followed by a `done` pulse.
- **k=7:** expect `err` high for exactly 1 cycle, `valid` and `busy` never asserted, and `word`/`idx` unchanged.
- **k=3 with `ready` randomly toggled:**
  - Expect 20 words with `word`/`idx` stable while `ready`=0.
  - The sequence equals the `ready`=1 sequence.
  - The final word is 111000.
- **`rst_n` pulled low after the 4th transfer of a k=3 run:** all outputs go to 0 immediately. A restart with k=1 yields 000001, 000010, 000100, 001000, 010000, 100000.
- **`start` pulsed with k=5 during a k=4 run:** the k=4 run completes with 15 words and the pulse is ignored. Sweep k=0..6 and check that the emitted counts sum to 64 distinct words.
